// File: rtl/mac_operand_fifo.sv
// Operand staging queue in front of the MAC pipeline. It buffers (a, b) pairs
// in a circular register queue and tags the last pair of each fixed-length burst.
module mac_operand_fifo #(
  parameter int p_nbits = 32,
  parameter int p_depth = 4,
  parameter int p_burst = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [p_nbits-1:0]         in_a,
  input  logic [p_nbits-1:0]         in_b,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [p_nbits-1:0]         out_a,
  output logic [p_nbits-1:0]         out_b,
  output logic                       out_last,
  output logic [$clog2(p_depth):0]   count
);

  localparam int ptr_w = $clog2(p_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam int bc_w  = $clog2(p_burst) + 1;

  logic [2*p_nbits-1:0] mem [p_depth];
  logic [ptr_w-1:0]     wr_ptr, rd_ptr;
  logic [bc_w-1:0]      burst_cnt;
  logic                 push, pop;
  logic [2*p_nbits-1:0] head;

  // Handshake status depends on registered occupancy only, so out_rdy never reaches in_rdy.
  assign in_rdy  = (count != cnt_w'(p_depth));
  assign out_val = (count != '0);
  assign push    = in_val && in_rdy;
  assign pop     = out_val && out_rdy;

  assign head     = mem[rd_ptr];
  assign out_a    = out_val ? head[2*p_nbits-1:p_nbits] : '0;
  assign out_b    = out_val ? head[p_nbits-1:0]         : '0;
  assign out_last = out_val && (burst_cnt == bc_w'(p_burst - 1));

  // NOTE: the data array has no reset; stale entries are never visible because
  // out_a/out_b are gated by out_val, and leaving it unreset keeps it plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);

      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase

      if (pop) begin
        if (burst_cnt == bc_w'(p_burst - 1)) burst_cnt <= '0;
        else                                  burst_cnt <= burst_cnt + bc_w'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_fifo.sv
// Directed bench for mac_operand_fifo: a queue/burst model predicts every
// output each cycle; popped pairs are compared against the scoreboard front.
module tb_mac_operand_fifo;

  localparam int NB = 32;
  localparam int DEPTH = 4;
  localparam int BURST = 5;

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val, in_rdy, out_val, out_rdy, out_last;
  logic [NB-1:0] in_a, in_b, out_a, out_b;
  logic [2:0]    count;

  pair_t sb[$];
  int    exp_bc;
  int    checks = 0;
  int    errors = 0;

  mac_operand_fifo #(.p_nbits(NB), .p_depth(DEPTH), .p_burst(BURST)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .out_val(out_val), .out_rdy(out_rdy), .out_a(out_a), .out_b(out_b),
    .out_last(out_last), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, as seen before the coming edge.
  task automatic check_outputs(input string tag);
    logic ev;
    ev = (sb.size() != 0);
    check({tag, ".count"},   64'(count),   64'(sb.size()));
    check({tag, ".in_rdy"},  64'(in_rdy),  64'(sb.size() != DEPTH));
    check({tag, ".out_val"}, 64'(out_val), 64'(ev));
    check({tag, ".out_a"},   64'(out_a),   ev ? 64'(sb[0].a) : 64'd0);
    check({tag, ".out_b"},   64'(out_b),   ev ? 64'(sb[0].b) : 64'd0);
    check({tag, ".out_last"}, 64'(out_last), 64'(ev && (exp_bc == BURST - 1)));
  endtask

  // One clock: drive inputs at posedge+2, check at posedge+4, update model at the edge.
  task automatic cycle(input string tag, input logic v, input logic [NB-1:0] a,
                       input logic [NB-1:0] b, input logic r);
    logic do_push, do_pop;
    in_val = v; in_a = a; in_b = b; out_rdy = r;
    #2;
    check_outputs(tag);
    do_push = v && (sb.size() != DEPTH);
    do_pop  = r && (sb.size() != 0);
    @(posedge clk);
    if (do_pop) begin
      void'(sb.pop_front());
      exp_bc = (exp_bc == BURST - 1) ? 0 : exp_bc + 1;
    end
    if (do_push) sb.push_back('{a: a, b: b});
    #2;
  endtask

  task automatic idle(input string tag, input logic r);
    cycle(tag, 1'b0, 32'hdead_beef, 32'hcafe_f00d, r);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    in_val = 1'b0; out_rdy = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    exp_bc = 0;
    check_outputs(tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [NB-1:0] ta [5] = '{32'd1, 32'd3, 32'd10, 32'd2, 32'd5};
  logic [NB-1:0] tb [5] = '{32'd2, 32'd10, 32'd1, 32'd12, 32'd13};
  logic [NB-1:0] hold_a, hold_b;
  logic          hold_last;

  initial begin
    reset = 1'b1; in_val = 1'b0; in_a = '0; in_b = '0; out_rdy = 1'b0;
    exp_bc = 0;
    #3;
    check_outputs("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // 1: back-to-back stream, one burst, out_last only on (5,13)
    for (int i = 0; i < 5; i++) cycle("stream", 1'b1, ta[i], tb[i], 1'b1);
    idle("stream_drain", 1'b1);
    idle("stream_empty", 1'b1);

    // 2: fill to full, fifth push refused, then drain
    for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 32'h100 + i, 32'h200 + i, 1'b0);
    check("fill.refused_at_full", 64'(in_rdy), 64'd0);
    for (int i = 0; i < 5; i++) idle("drain", 1'b1);

    // 3: hold count=2 with simultaneous push/pop, pointers wrap several times
    cycle("pp_pre", 1'b1, 32'h300, 32'h400, 1'b0);
    cycle("pp_pre", 1'b1, 32'h301, 32'h401, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("pushpop", 1'b1, 32'h310 + i, 32'h410 + i, 1'b1);
      check("pushpop.count2", 64'(count), 64'd2);
    end
    idle("pp_drain", 1'b1);
    idle("pp_drain", 1'b1);

    // 4: fresh burst count, 12 pops with periodic stalls
    async_reset("reset_before_pops");
    cycle("pops_pre", 1'b1, 32'h500, 32'h600, 1'b0);
    for (int i = 1; i < 12; i++) begin
      if (i % 4 == 0) begin
        hold_a = out_a; hold_b = out_b; hold_last = out_last;
        cycle("stall", 1'b0, 32'h0, 32'h0, 1'b0);
        check("stall.a_stable", 64'(out_a), 64'(hold_a));
        check("stall.b_stable", 64'(out_b), 64'(hold_b));
        check("stall.last_stable", 64'(out_last), 64'(hold_last));
      end
      cycle("pops", 1'b1, 32'h500 + i, 32'h600 + i, 1'b1);
    end
    idle("pops_last", 1'b1);
    check("pops.burst_phase", 64'(exp_bc), 64'd2);

    // 5: async reset with count=3 and burst counter=2, then a full new burst
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 32'h700 + i, 32'h800 + i, 1'b0);
    async_reset("async_reset");
    check("async_reset.in_rdy", 64'(in_rdy), 64'd1);
    for (int i = 0; i < 5; i++) cycle("post_rst", 1'b1, 32'h900 + i, 32'ha00 + i, 1'b1);
    idle("post_rst_drain", 1'b1);

    // 6: empty with out_rdy high must not move the burst counter
    cycle("empty_pre", 1'b1, 32'hb00, 32'hc00, 1'b1);
    cycle("empty_pre", 1'b1, 32'hb01, 32'hc01, 1'b1);
    idle("empty_pre", 1'b1);
    for (int i = 0; i < 5; i++) idle("empty_idle", 1'b1);
    for (int i = 0; i < 3; i++) cycle("after_empty", 1'b1, 32'hb10 + i, 32'hc10 + i, 1'b1);
    idle("after_empty_drain", 1'b1);
    idle("after_empty_done", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
